// File: rtl/wb_stage.sv
// Writeback stage: one commit register between the memory stage and the register file.
// Forms load data at accept time and retires into the RF and trace port when not stalled.
module wb_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_wb_valid,
    output logic        o_wb_ready,
    input  logic [31:0] wb_alu_res,
    input  logic [31:0] wb_mem_rdata,
    input  logic [4:0]  wb_rf_waddr,
    input  logic        wb_rf_we,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_inst,
    input  logic        i_trace_stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        fwd_valid,
    output logic [4:0]  fwd_addr,
    output logic [31:0] fwd_data,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
    output logic [31:0] retire_cnt,
    output logic        o_align_err
);

    typedef enum logic [2:0] {
        LD_NONE,
        LD_B,
        LD_H,
        LD_W,
        LD_BU,
        LD_HU
    } ld_kind_e;

    ld_kind_e    ld_kind;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;
    logic        misalign;
    logic        accept;
    logic        fire;

    logic        c_valid;
    logic [31:0] c_pc;
    logic [4:0]  c_waddr;
    logic        c_we;
    logic [31:0] c_wdata;
    logic [31:0] retire_q;
    logic        align_q;

    // Only the major opcode field selects the load flavour; the rest is don't-care here.
    logic unused_inst_bits;
    assign unused_inst_bits = ^wb_inst[21:0];

    always_comb begin
        ld_kind = LD_NONE;
        case (wb_inst[31:22])
            10'h0A0: ld_kind = LD_B;
            10'h0A1: ld_kind = LD_H;
            10'h0A2: ld_kind = LD_W;
            10'h0A8: ld_kind = LD_BU;
            10'h0A9: ld_kind = LD_HU;
            default: ld_kind = LD_NONE;
        endcase
    end

    always_comb begin
        byte_lane = wb_mem_rdata[7:0];
        case (wb_alu_res[1:0])
            2'd0: byte_lane = wb_mem_rdata[7:0];
            2'd1: byte_lane = wb_mem_rdata[15:8];
            2'd2: byte_lane = wb_mem_rdata[23:16];
            2'd3: byte_lane = wb_mem_rdata[31:24];
            default: byte_lane = wb_mem_rdata[7:0];
        endcase
        half_lane = wb_alu_res[1] ? wb_mem_rdata[31:16] : wb_mem_rdata[15:0];
    end

    // Misaligned loads still produce lane-selected data; only the sticky flag reports them.
    always_comb begin
        load_data = wb_alu_res;
        misalign  = 1'b0;
        case (ld_kind)
            LD_B:  load_data = {{24{byte_lane[7]}}, byte_lane};
            LD_BU: load_data = {24'h0, byte_lane};
            LD_H: begin
                load_data = {{16{half_lane[15]}}, half_lane};
                misalign  = wb_alu_res[0];
            end
            LD_HU: begin
                load_data = {16'h0, half_lane};
                misalign  = wb_alu_res[0];
            end
            LD_W: begin
                load_data = wb_mem_rdata;
                misalign  = |wb_alu_res[1:0];
            end
            default: load_data = wb_alu_res;
        endcase
    end

    assign o_wb_ready = ~c_valid | ~i_trace_stall;
    assign accept     = i_wb_valid & o_wb_ready;
    // Gated by reset so a held entry never retires in the cycle reset is applied.
    assign fire       = c_valid & ~i_trace_stall & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_valid  <= 1'b0;
            c_pc     <= 32'h0;
            c_waddr  <= 5'h0;
            c_we     <= 1'b0;
            c_wdata  <= 32'h0;
            retire_q <= 32'h0;
            align_q  <= 1'b0;
        end else begin
            if (accept) begin
                c_valid <= 1'b1;
                c_pc    <= wb_pc;
                c_waddr <= wb_rf_waddr;
                c_we    <= wb_rf_we;
                c_wdata <= load_data;
            end else if (fire) begin
                c_valid <= 1'b0;
            end
            if (fire)
                retire_q <= retire_q + 32'd1;
            if (accept && misalign)
                align_q <= 1'b1;
        end
    end

    assign rf_we             = fire & c_we & (c_waddr != 5'd0);
    assign rf_waddr          = c_waddr;
    assign rf_wdata          = c_wdata;

    assign fwd_valid         = c_valid & c_we & (c_waddr != 5'd0);
    assign fwd_addr          = c_waddr;
    assign fwd_data          = c_wdata;

    assign debug_wb_pc       = c_pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = c_waddr;
    assign debug_wb_rf_wdata = c_wdata;

    assign retire_cnt        = retire_q;
    assign o_align_err       = align_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: hand-computed expectations checked with immediate assertions.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_wb_valid;
    logic        o_wb_ready;
    logic [31:0] wb_alu_res;
    logic [31:0] wb_mem_rdata;
    logic [4:0]  wb_rf_waddr;
    logic        wb_rf_we;
    logic [31:0] wb_pc;
    logic [31:0] wb_inst;
    logic        i_trace_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic [31:0] retire_cnt;
    logic        o_align_err;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ALU  = 32'h0000_0000;
    localparam logic [31:0] I_LDB  = 32'h2800_0000;
    localparam logic [31:0] I_LDH  = 32'h2840_0000;
    localparam logic [31:0] I_LDW  = 32'h2880_0000;
    localparam logic [31:0] I_LDBU = 32'h2A00_0000;
    localparam logic [31:0] I_LDHU = 32'h2A40_0000;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_wb_valid        (i_wb_valid),
        .o_wb_ready        (o_wb_ready),
        .wb_alu_res        (wb_alu_res),
        .wb_mem_rdata      (wb_mem_rdata),
        .wb_rf_waddr       (wb_rf_waddr),
        .wb_rf_we          (wb_rf_we),
        .wb_pc             (wb_pc),
        .wb_inst           (wb_inst),
        .i_trace_stall     (i_trace_stall),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .fwd_valid         (fwd_valid),
        .fwd_addr          (fwd_addr),
        .fwd_data          (fwd_data),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .retire_cnt        (retire_cnt),
        .o_align_err       (o_align_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] wa,
                         input logic we, input logic [31:0] alu, input logic [31:0] rd,
                         input logic [31:0] inst);
        i_wb_valid   = v;
        wb_pc        = pc;
        wb_rf_waddr  = wa;
        wb_rf_we     = we;
        wb_alu_res   = alu;
        wb_mem_rdata = rd;
        wb_inst      = inst;
    endtask

    initial begin
        rst_n         = 1'b0;
        i_trace_stall = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, I_ALU);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 32'(o_wb_ready), 32'd1);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("rst_dbg_pc", debug_wb_pc, 32'h0);
        chk("rst_dbg_we", 32'(debug_wb_rf_we), 32'd0);
        chk("rst_dbg_wnum", 32'(debug_wb_rf_wnum), 32'd0);
        chk("rst_dbg_wdata", debug_wb_rf_wdata, 32'h0);
        chk("rst_retire", retire_cnt, 32'd0);
        chk("rst_align", 32'(o_align_err), 32'd0);

        // back-to-back ALU ops, no bubbles
        drive(1'b1, 32'h1C00_0000, 5'd1, 1'b1, 32'h11, 32'h0, I_ALU);
        tick();
        drive(1'b1, 32'h1C00_0004, 5'd2, 1'b1, 32'h22, 32'h0, I_ALU);
        #1;
        chk("b2b1_rf_we", 32'(rf_we), 32'd1);
        chk("b2b1_waddr", 32'(rf_waddr), 32'd1);
        chk("b2b1_wdata", rf_wdata, 32'h11);
        chk("b2b1_pc", debug_wb_pc, 32'h1C00_0000);
        chk("b2b1_ready", 32'(o_wb_ready), 32'd1);
        tick();
        drive(1'b1, 32'h1C00_0008, 5'd3, 1'b1, 32'h33, 32'h0, I_ALU);
        #1;
        chk("b2b2_rf_we", 32'(rf_we), 32'd1);
        chk("b2b2_waddr", 32'(rf_waddr), 32'd2);
        chk("b2b2_wdata", rf_wdata, 32'h22);
        tick();
        drive(1'b0, 32'h0, 5'd9, 1'b1, 32'hDEAD, 32'h0, I_ALU);
        #1;
        chk("b2b3_rf_we", 32'(rf_we), 32'd1);
        chk("b2b3_waddr", 32'(rf_waddr), 32'd3);
        chk("b2b3_wdata", rf_wdata, 32'h33);
        chk("b2b3_dbg_we", 32'(debug_wb_rf_we), 32'hF);
        tick();
        chk("b2b_idle_rf_we", 32'(rf_we), 32'd0);
        chk("b2b_idle_nocapture", 32'(debug_wb_rf_wnum), 32'd3);
        chk("b2b_retire", retire_cnt, 32'd3);

        // load extension
        drive(1'b1, 32'h1C00_0010, 5'd4, 1'b1, 32'h1C00_1001, 32'h1234_80FF, I_LDB);
        tick();
        chk("ldb", rf_wdata, 32'hFFFF_FF80);
        drive(1'b1, 32'h1C00_0014, 5'd5, 1'b1, 32'h1C00_1001, 32'h1234_80FF, I_LDBU);
        tick();
        chk("ldbu", rf_wdata, 32'h0000_0080);
        drive(1'b1, 32'h1C00_0018, 5'd6, 1'b1, 32'h1C00_1002, 32'h1234_80FF, I_LDHU);
        tick();
        chk("ldhu", rf_wdata, 32'h0000_1234);
        drive(1'b1, 32'h1C00_001C, 5'd7, 1'b1, 32'h1C00_1000, 32'h1234_80FF, I_LDH);
        tick();
        chk("ldh", rf_wdata, 32'hFFFF_80FF);
        drive(1'b1, 32'h1C00_0020, 5'd8, 1'b1, 32'h1C00_1000, 32'h1234_80FF, I_LDW);
        tick();
        chk("ldw", rf_wdata, 32'h1234_80FF);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, I_ALU);
        tick();
        chk("ld_retire", retire_cnt, 32'd8);
        chk("ld_align_clean", 32'(o_align_err), 32'd0);

        // trace stall holds the entry; waiting entry accepted on release
        drive(1'b1, 32'h1C00_0030, 5'd7, 1'b1, 32'hAA, 32'h0, I_ALU);
        tick();
        i_trace_stall = 1'b1;
        drive(1'b1, 32'h1C00_0034, 5'd9, 1'b1, 32'hBB, 32'h0, I_ALU);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_ready", 32'(o_wb_ready), 32'd0);
            chk("stall_rf_we", 32'(rf_we), 32'd0);
            chk("stall_fwd_valid", 32'(fwd_valid), 32'd1);
            chk("stall_fwd_addr", 32'(fwd_addr), 32'd7);
            chk("stall_fwd_data", fwd_data, 32'hAA);
            chk("stall_pc", debug_wb_pc, 32'h1C00_0030);
            chk("stall_retire", retire_cnt, 32'd8);
            tick();
        end
        i_trace_stall = 1'b0;
        #1;
        chk("release_rf_we", 32'(rf_we), 32'd1);
        chk("release_ready", 32'(o_wb_ready), 32'd1);
        chk("release_wdata", rf_wdata, 32'hAA);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, I_ALU);
        #1;
        chk("release_next_pc", debug_wb_pc, 32'h1C00_0034);
        chk("release_next_wdata", rf_wdata, 32'hBB);
        chk("release_retire", retire_cnt, 32'd9);
        tick();
        chk("stall_seq_retire", retire_cnt, 32'd10);

        // r0 destination never writes but still retires
        drive(1'b1, 32'h1C00_0040, 5'd0, 1'b1, 32'h55, 32'h0, I_ALU);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, I_ALU);
        #1;
        chk("r0_rf_we", 32'(rf_we), 32'd0);
        chk("r0_dbg_we", 32'(debug_wb_rf_we), 32'd0);
        chk("r0_fwd_valid", 32'(fwd_valid), 32'd0);
        tick();
        chk("r0_retire", retire_cnt, 32'd11);

        // misaligned ld.w sets sticky flag, data unshifted
        drive(1'b1, 32'h1C00_0050, 5'd10, 1'b1, 32'h1C00_1002, 32'hCAFE_BABE, I_LDW);
        tick();
        drive(1'b1, 32'h1C00_0054, 5'd11, 1'b1, 32'h1C00_1004, 32'h0BAD_F00D, I_LDW);
        #1;
        chk("mis_align", 32'(o_align_err), 32'd1);
        chk("mis_wdata", rf_wdata, 32'hCAFE_BABE);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, I_ALU);
        #1;
        chk("mis_sticky", 32'(o_align_err), 32'd1);
        chk("mis_good_wdata", rf_wdata, 32'h0BAD_F00D);
        tick();
        chk("mis_retire", retire_cnt, 32'd13);

        // reset while an entry is held under stall
        drive(1'b1, 32'h1C00_0060, 5'd12, 1'b1, 32'h77, 32'h0, I_ALU);
        tick();
        i_trace_stall = 1'b1;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, I_ALU);
        tick();
        chk("rstmid_held_fwd", 32'(fwd_valid), 32'd1);
        rst_n = 1'b0;
        i_trace_stall = 1'b0;
        #1;
        chk("rstmid_no_fire", 32'(rf_we), 32'd0);
        tick();
        chk("rstmid_fwd", 32'(fwd_valid), 32'd0);
        chk("rstmid_pc", debug_wb_pc, 32'h0);
        chk("rstmid_retire", retire_cnt, 32'd0);
        chk("rstmid_align", 32'(o_align_err), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rstmid_after_rf_we", 32'(rf_we), 32'd0);
        chk("rstmid_after_retire", retire_cnt, 32'd0);

        // counter wrap
        drive(1'b1, 32'h1C00_0070, 5'd13, 1'b1, 32'h99, 32'h0, I_ALU);
        i_trace_stall = 1'b1;
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, I_ALU);
        force dut.retire_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_q;
        #1;
        chk("wrap_preload", retire_cnt, 32'hFFFF_FFFF);
        i_trace_stall = 1'b0;
        tick();
        chk("wrap_zero", retire_cnt, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: i_wb_valid  input  1  upstream entry valid; o_wb_ready  output  1  stage can accept.
REQ-004 SHALL have ports: wb_alu_res  input  32  ALU result / load address; wb_mem_rdata  input  32  raw load word.
REQ-005 SHALL have ports: wb_rf_waddr  input  5; wb_rf_we  input  1; wb_pc  input  32; wb_inst  input  32.
REQ-006 SHALL have port: i_trace_stall  input  1  trace/commit backpressure.
REQ-007 SHALL have ports: rf_we  output  1; rf_waddr  output  5; rf_wdata  output  32  register-file write port.
REQ-008 SHALL have ports: fwd_valid  output  1; fwd_addr  output  5; fwd_data  output  32  bypass to decode.
REQ-009 SHALL have ports: debug_wb_pc  output  32; debug_wb_rf_we  output  4; debug_wb_rf_wnum  output  5; debug_wb_rf_wdata  output  32.
REQ-010 SHALL have ports: retire_cnt  output  32  committed-instruction count; o_align_err  output  1  sticky misaligned-load flag.

Function
REQ-011 SHALL hold one commit register (c_valid plus pc, waddr, we, wdata).
REQ-012 SHALL drive o_wb_ready = ~c_valid | ~i_trace_stall (combinational).
REQ-013 SHALL accept an entry when i_wb_valid & o_wb_ready; accepted data appears in the commit register next cycle (latency 1).
REQ-014 SHALL fire a commit when c_valid & ~i_trace_stall; on fire without a new accept, c_valid clears next cycle.
REQ-015 SHALL, on simultaneous fire and accept, load the new entry with c_valid staying 1 (full throughput, no bubble).
REQ-016 SHALL, while c_valid & i_trace_stall, hold all commit-register contents unchanged.
REQ-017 SHALL decode load type from wb_inst[31:22]: 0x0A0 ld.b, 0x0A1 ld.h, 0x0A2 ld.w, 0x0A8 ld.bu, 0x0A9 ld.hu; any other value is non-load.
REQ-018 SHALL select byte lane wb_alu_res[1:0] and halfword lane wb_alu_res[1]; ld.b/ld.h sign-extend, ld.bu/ld.hu zero-extend, ld.w passes the word.
REQ-019 SHALL compute wdata = aligned load data for loads, else wb_alu_res, captured at accept.
REQ-020 SHALL set o_align_err (sticky until reset) on accepting ld.h/ld.hu with addr[0]=1 or ld.w with addr[1:0]!=0; data is still formed from the selected lane, ld.w passes the word unshifted.
REQ-021 SHALL drive rf_we = fire & c_we & (c_waddr != 0); rf_waddr = c_waddr; rf_wdata = c_wdata.
REQ-022 SHALL drive fwd_valid = c_valid & c_we & (c_waddr != 0), independent of i_trace_stall; fwd_addr/fwd_data from the commit register.
REQ-023 SHALL drive debug_wb_pc = c_pc, debug_wb_rf_we = {4{rf_we}}, debug_wb_rf_wnum = c_waddr, debug_wb_rf_wdata = c_wdata.
REQ-024 SHALL increment retire_cnt by 1 on every fire, including non-writing instructions; wrap from 0xFFFFFFFF to 0.
REQ-025 SHALL not capture data when i_wb_valid=0, regardless of wb_* values.

Reset
REQ-026 SHALL, with rst_n=0 at a clock edge: c_valid=0, retire_cnt=0, o_align_err=0, c_we=0, c_waddr=0, c_pc=0, c_wdata=0.
REQ-027 SHALL therefore show after reset: o_wb_ready=1, rf_we=0, fwd_valid=0, all debug outputs 0.
REQ-028 SHALL, on reset asserted mid-stall, discard the held entry; no commit fires in that cycle or after it.

Verification
REQ-029 Back-to-back ALU ops: pc 0x1C000000/04/08 with waddr 1/2/3, we=1, alu_res 0x11/0x22/0x33, no stall -> rf writes on consecutive cycles with matching data; retire_cnt=3.
REQ-030 Load extension: ld.b with addr 0x...01 and rdata 0x1234_80FF -> wdata 0xFFFFFF80; ld.bu -> 0x00000080; ld.hu with addr 0x...02 -> 0x00001234.
REQ-031 Stall: i_trace_stall=1 for 3 cycles with entry held -> o_wb_ready=0, rf_we=0, fwd_valid=1, retire_cnt unchanged; on release one commit fires and a waiting entry is accepted in the same cycle.
REQ-032 r0 write: waddr=0, we=1 -> rf_we=0, debug_wb_rf_we=0, fwd_valid=0, retire_cnt+1.
REQ-033 Misalign: ld.w with addr 0x...02 -> o_align_err=1 and stays 1 through later good loads until rst_n=0.
REQ-034 Reset mid-stall and counter wrap: reset while c_valid=1 -> c_valid=0 next cycle; preload retire_cnt to 0xFFFFFFFF (force) and commit once -> 0.
